// File: rtl/piezo_pkg.sv
// Shared definitions for the piezo melody scheduler: melody codes, request
// bit positions, scheduler state encoding and the note count per melody.
package piezo_pkg;

   // Melody codes driven on note_state
   localparam logic [3:0] NOTE_NONE  = 4'd0;
   localparam logic [3:0] NOTE_100W  = 4'd1;
   localparam logic [3:0] NOTE_500W  = 4'd2;
   localparam logic [3:0] NOTE_1000W = 4'd3;
   localparam logic [3:0] NOTE_PROD1 = 4'd4;
   localparam logic [3:0] NOTE_PROD2 = 4'd5;
   localparam logic [3:0] NOTE_PROD3 = 4'd6;

   // Request bit positions (higher index = higher priority)
   localparam int REQ_100W  = 0;
   localparam int REQ_500W  = 1;
   localparam int REQ_1000W = 2;
   localparam int REQ_PROD1 = 3;
   localparam int REQ_PROD2 = 4;
   localparam int REQ_PROD3 = 5;

   // Notes per melody; note_played runs 1..NOTE_COUNT
   localparam logic [2:0] NOTE_COUNT = 3'd4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } sched_state_t;

   // Request bit index to melody code; the codes are laid out so that
   // bit n maps to code n+1
   function automatic logic [3:0] code_of(input logic [2:0] idx);
      return {1'b0, idx} + 4'd1;
   endfunction

endpackage

// File: rtl/prio_encoder6.sv
// 6-bit fixed-priority encoder: bit 5 wins. Returns a valid flag and the
// index of the highest set bit (0 when nothing is set).
module prio_encoder6 (
   input  logic [5:0] req,
   output logic       valid,
   output logic [2:0] idx
);

   logic [5:0] sel;

   // A bit is selected when it is set and no higher bit is set
   for (genvar gi = 0; gi < 6; gi++) begin : g_sel
      assign sel[gi] = req[gi] & ~(|(req >> (gi + 1)));
   end

   assign valid = |req;

   // At most one sel bit is high, so OR-ing the indices is the encoding
   always_comb begin
      idx = 3'd0;
      for (int i = 0; i < 6; i++) begin
         if (sel[i]) idx = idx | 3'(i);
      end
   end

endmodule

// File: rtl/piezo_melody_scheduler.sv
// Piezo melody scheduler: latches melody requests from the vending FSM,
// grants the highest-priority one, and steps the tone generator through
// four timed notes followed by a silent gap.
// Optional build macro PIEZO_PREEMPT_EN: a strictly higher-priority pending
// request aborts the current melody (no done pulse) and is played after GAP.
module piezo_melody_scheduler
   import piezo_pkg::*;
#(
   parameter int NOTE_TICKS = 250000,
   parameter int GAP_TICKS  = 50000,
   parameter int CNT_W      = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] req,
   output logic [3:0] note_state,
   output logic [2:0] note_played,
   output logic       busy,
   output logic       done,
   output logic [5:0] pending
);

   localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_TICKS - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);

   sched_state_t     state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [5:0]       pending_reg;
   logic [3:0]       note_state_reg;
   logic [2:0]       note_played_reg;
   logic             busy_reg;
   logic             done_reg;

   logic             grant_valid;
   logic [2:0]       grant_idx;
   logic [5:0]       grant_mask;
   logic             preempt;

   // Arbitration works only on the registered pending vector, so req never
   // reaches an output combinationally
   prio_encoder6 u_prio (
      .req   (pending_reg),
      .valid (grant_valid),
      .idx   (grant_idx)
   );

   assign grant_mask = 6'b000001 << grant_idx;

`ifdef PIEZO_PREEMPT_EN
   // Abort when a pending melody outranks the one playing
   assign preempt = grant_valid && (code_of(grant_idx) > note_state_reg);
`else
   assign preempt = 1'b0;
`endif

   // Scheduler FSM with registered outputs and request latching
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg       <= IDLE;
         cnt_reg         <= '0;
         pending_reg     <= '0;
         note_state_reg  <= NOTE_NONE;
         note_played_reg <= 3'd0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
      end else begin
         done_reg    <= 1'b0;
         pending_reg <= pending_reg | req;
         case (state_reg)
            IDLE: begin
               if (grant_valid) begin
                  // A re-pulse of the granted bit on this cycle survives
                  pending_reg     <= (pending_reg & ~grant_mask) | req;
                  note_state_reg  <= code_of(grant_idx);
                  note_played_reg <= 3'd1;
                  cnt_reg         <= '0;
                  busy_reg        <= 1'b1;
                  state_reg       <= PLAY;
               end
            end
            PLAY: begin
               if (preempt) begin
                  note_played_reg <= 3'd0;
                  note_state_reg  <= NOTE_NONE;
                  cnt_reg         <= '0;
                  state_reg       <= GAP;
               end else if (cnt_reg == NOTE_LAST) begin
                  cnt_reg <= '0;
                  if (note_played_reg < NOTE_COUNT) begin
                     note_played_reg <= note_played_reg + 3'd1;
                  end else begin
                     note_played_reg <= 3'd0;
                     note_state_reg  <= NOTE_NONE;
                     done_reg        <= 1'b1;
                     state_reg       <= GAP;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            GAP: begin
               if (cnt_reg == GAP_LAST) begin
                  cnt_reg   <= '0;
                  busy_reg  <= 1'b0;
                  state_reg <= IDLE;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
               cnt_reg   <= '0;
            end
         endcase
      end
   end

   assign note_state  = note_state_reg;
   assign note_played = note_played_reg;
   assign busy        = busy_reg;
   assign done        = done_reg;
   assign pending     = pending_reg;

endmodule

// File: tb/tb_piezo_melody_scheduler.sv
// Directed testbench for piezo_melody_scheduler with NOTE_TICKS=4, GAP_TICKS=2.
module tb_piezo_melody_scheduler;

   logic       clk;
   logic       rst;
   logic [5:0] req;
   logic [3:0] note_state;
   logic [2:0] note_played;
   logic       busy;
   logic       done;
   logic [5:0] pending;

   int checks = 0;
   int errors = 0;

   piezo_melody_scheduler #(
      .NOTE_TICKS (4),
      .GAP_TICKS  (2),
      .CNT_W      (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .note_state  (note_state),
      .note_played (note_played),
      .busy        (busy),
      .done        (done),
      .pending     (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges and settle 1 time unit past the last one
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Called at the sample right after a grant edge. Checks all 16 note
   // cycles, the done pulse, the 2-cycle gap and busy dropping. inj is
   // driven on req for the first playback cycle; exp_pend is the pending
   // vector expected after that cycle.
   task automatic play_check(input logic [3:0] code, input logic [5:0] inj,
                             input logic [5:0] exp_pend);
      for (int n = 0; n < 16; n++) begin
         chk("note_played", {5'd0, note_played}, 8'(n / 4 + 1));
         chk("note_state", {4'd0, note_state}, {4'd0, code});
         if (n == 0) req = inj;
         tick(1);
         if (n == 0) begin
            req = 6'd0;
            chk("pending_in_play", {2'd0, pending}, {2'd0, exp_pend});
         end
      end
      chk("done_pulse", {7'd0, done}, 8'd1);
      chk("silent_np", {5'd0, note_played}, 8'd0);
      chk("silent_ns", {4'd0, note_state}, 8'd0);
      chk("busy_gap0", {7'd0, busy}, 8'd1);
      tick(1);
      chk("done_once", {7'd0, done}, 8'd0);
      chk("busy_gap1", {7'd0, busy}, 8'd1);
      tick(1);
      chk("busy_idle", {7'd0, busy}, 8'd0);
      $display("melody code %0d complete", code);
   endtask

   initial begin
      rst = 1'b0;
      req = 6'd0;
      tick(2);
      chk("rst_ns", {4'd0, note_state}, 8'd0);
      chk("rst_np", {5'd0, note_played}, 8'd0);
      chk("rst_busy", {7'd0, busy}, 8'd0);
      chk("rst_done", {7'd0, done}, 8'd0);
      chk("rst_pend", {2'd0, pending}, 8'd0);
      $display("reset applied");
      rst = 1'b1;

      // Single 100w request: latch then grant
      req = 6'b000001;
      tick(1);
      req = 6'd0;
      chk("t1_latch_pend", {2'd0, pending}, 8'd1);
      chk("t1_latch_np", {5'd0, note_played}, 8'd0);
      tick(1);
      chk("t1_grant_busy", {7'd0, busy}, 8'd1);
      chk("t1_grant_pend", {2'd0, pending}, 8'd0);
      play_check(4'd1, 6'd0, 6'd0);

      // prod1 and 100w together: prod1 first
      req = 6'b001001;
      tick(1);
      req = 6'd0;
      tick(1);
      play_check(4'd4, 6'd0, 6'b000001);
      tick(1);
      play_check(4'd1, 6'd0, 6'd0);

      // prod2 re-requested during its own playback replays once
      req = 6'b010000;
      tick(1);
      req = 6'd0;
      tick(1);
      play_check(4'd5, 6'b010000, 6'b010000);
      tick(1);
      play_check(4'd5, 6'd0, 6'd0);
      tick(2);
      chk("t3_no_third", {7'd0, busy}, 8'd0);

      // Reset mid-melody at note 3 drops playback and pending
      req = 6'b001001;
      tick(1);
      req = 6'd0;
      tick(1);
      tick(8);
      chk("t4_np3", {5'd0, note_played}, 8'd3);
      chk("t4_pend_before", {2'd0, pending}, 8'd1);
      rst = 1'b0;
      tick(1);
      rst = 1'b1;
      chk("t4_ns", {4'd0, note_state}, 8'd0);
      chk("t4_np", {5'd0, note_played}, 8'd0);
      chk("t4_busy", {7'd0, busy}, 8'd0);
      chk("t4_done", {7'd0, done}, 8'd0);
      chk("t4_pend", {2'd0, pending}, 8'd0);
      tick(3);
      chk("t4_stay_idle", {7'd0, busy}, 8'd0);
      chk("t4_stay_ns", {4'd0, note_state}, 8'd0);
      $display("mid-melody reset done");

      // Granted bit re-pulsed on its grant cycle plays twice
      req = 6'b000010;
      tick(1);
      tick(1);
      req = 6'd0;
      chk("t5_pend_kept", {2'd0, pending}, 8'd2);
      play_check(4'd2, 6'd0, 6'b000010);
      tick(1);
      play_check(4'd2, 6'd0, 6'd0);

      // 100w at note 2, then prod3 arrives
      req = 6'b000001;
      tick(1);
      req = 6'd0;
      tick(1);
      tick(4);
      chk("t6_np2", {5'd0, note_played}, 8'd2);
      req = 6'b100000;
      tick(1);
      req = 6'd0;
      chk("t6_pend", {2'd0, pending}, 8'd32);
`ifdef PIEZO_PREEMPT_EN
      tick(1);
      chk("t6_abort_np", {5'd0, note_played}, 8'd0);
      chk("t6_abort_ns", {4'd0, note_state}, 8'd0);
      chk("t6_abort_nodone", {7'd0, done}, 8'd0);
      chk("t6_abort_busy", {7'd0, busy}, 8'd1);
      tick(1);
      chk("t6_gap_nodone", {7'd0, done}, 8'd0);
      chk("t6_gap_busy", {7'd0, busy}, 8'd1);
      tick(1);
      chk("t6_idle", {7'd0, busy}, 8'd0);
      tick(1);
      $display("preempted 100w by prod3");
`else
      tick(3);
      chk("t6_np3", {5'd0, note_played}, 8'd3);
      tick(4);
      chk("t6_np4", {5'd0, note_played}, 8'd4);
      chk("t6_ns1", {4'd0, note_state}, 8'd1);
      tick(4);
      chk("t6_done", {7'd0, done}, 8'd1);
      tick(2);
      chk("t6_idle", {7'd0, busy}, 8'd0);
      tick(1);
      $display("100w completed before prod3");
`endif
      chk("t6_pend_clear", {2'd0, pending}, 8'd0);
      play_check(4'd6, 6'd0, 6'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
